ldm_stm_sequencer: RTL

- Sequences ARM block transfers (LDM/STM) between the 16x32 register file and the data memory port, one register per memory beat.
- Walks the register list in ascending order and computes addresses for the IA/IB/DA/DB modes.
- Drives a regfile read port (STM) or the regfile write port (LDM), then performs base writeback.
- Sits between the decode/control unit and the regfile/memory interface; the control unit stalls while busy=1.

---
 rtl/ldm_stm_sequencer_if.sv | 45 ++++
 rtl/ldm_stm_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer_if.sv
// Bundle between the LDM/STM sequencer and its surroundings: request fields
// from control, the data memory beat handshake and the regfile ports.
interface ldm_stm_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int REG_N   = 16,
    parameter int RADDR_W = 4
);
    logic               start;
    logic               is_load;
    logic [REG_N-1:0]   reg_list;
    logic [RADDR_W-1:0] base_reg;
    logic [DATA_W-1:0]  base_val;
    logic               up;
    logic               pre;
    logic               wb;
    logic               busy;
    logic               done;

    logic [DATA_W-1:0]  mem_addr;
    logic               mem_rd;
    logic               mem_wr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ready;

    logic [RADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0]  rf_rd_data;
    logic               rf_w_en;
    logic [RADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0]  rf_w_data;

    modport slave (
        input  start, is_load, reg_list, base_reg, base_val, up, pre, wb,
               mem_rdata, mem_ready, rf_rd_data,
        output busy, done, mem_addr, mem_rd, mem_wr, mem_wdata,
               rf_rd_addr, rf_w_en, rf_w_addr, rf_w_data
    );

    modport master (
        output start, is_load, reg_list, base_reg, base_val, up, pre, wb,
               mem_rdata, mem_ready, rf_rd_data,
        input  busy, done, mem_addr, mem_rd, mem_wr, mem_wdata,
               rf_rd_addr, rf_w_en, rf_w_addr, rf_w_data
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM block-transfer sequencer: one register per memory beat, ascending
// register order, IA/IB/DA/DB addressing, optional base writeback at the end.
module ldm_stm_sequencer #(
    parameter int DATA_W  = 32,
    parameter int REG_N   = 16,
    parameter int RADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ldm_stm_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(REG_N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_reg;
    logic [REG_N-1:0]   list_reg;
    logic [DATA_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wb_val_reg;
    logic [RADDR_W-1:0] rn_reg;
    logic               ld_reg;
    logic               do_wb_reg;

    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  base;
    logic [DATA_W-1:0]  span;
    logic [DATA_W-1:0]  first_addr;
    logic [RADDR_W-1:0] idx;
    logic [REG_N-1:0]   list_next;
    logic               xfer;
    logic               beat_done;
    logic               wb_state;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < REG_N; i++) begin
            cnt = cnt + CNT_W'(bus.reg_list[i]);
        end
    end

    assign base = bus.base_val & ~DATA_W'(3);
    assign span = DATA_W'(cnt) << 2;

    always_comb begin
        first_addr = base;
        case ({bus.up, bus.pre})
            2'b10:   first_addr = base;
            2'b11:   first_addr = base + DATA_W'(4);
            2'b00:   first_addr = base - span + DATA_W'(4);
            default: first_addr = base - span;
        endcase
    end

    // Lowest remaining set bit is the register served by the current beat.
    always_comb begin
        idx = '0;
        for (int i = REG_N - 1; i >= 0; i--) begin
            if (list_reg[i]) begin
                idx = RADDR_W'(i);
            end
        end
    end

    assign list_next = list_reg & (list_reg - REG_N'(1));
    assign xfer      = (state_reg == S_XFER);
    assign beat_done = xfer && bus.mem_ready;
    assign wb_state  = (state_reg == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            list_reg   <= '0;
            addr_reg   <= '0;
            wb_val_reg <= '0;
            rn_reg     <= '0;
            ld_reg     <= 1'b0;
            do_wb_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        list_reg   <= bus.reg_list;
                        addr_reg   <= first_addr;
                        wb_val_reg <= bus.up ? (base + span) : (base - span);
                        rn_reg     <= bus.base_reg;
                        ld_reg     <= bus.is_load;
                        // A loaded base register keeps the loaded value.
                        do_wb_reg  <= bus.wb && !(bus.is_load && bus.reg_list[bus.base_reg]);
                        if (bus.reg_list != '0) begin
                            state_reg <= S_XFER;
                        end else if (bus.wb) begin
                            state_reg <= S_WB;
                        end else begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_XFER: begin
                    if (bus.mem_ready) begin
                        list_reg <= list_next;
                        addr_reg <= addr_reg + DATA_W'(4);
                        if (list_next == '0) begin
                            state_reg <= do_wb_reg ? S_WB : S_DONE;
                        end
                    end
                end
                S_WB:    state_reg <= S_DONE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state_reg != S_IDLE);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.mem_rd     = xfer && ld_reg;
    assign bus.mem_wr     = xfer && !ld_reg;
    assign bus.mem_addr   = xfer ? addr_reg : '0;
    assign bus.rf_rd_addr = (xfer && !ld_reg) ? idx : '0;
    assign bus.mem_wdata  = (xfer && !ld_reg) ? bus.rf_rd_data : '0;

    assign bus.rf_w_en    = (beat_done && ld_reg) || wb_state;
    assign bus.rf_w_addr  = wb_state ? rn_reg :
                            (beat_done && ld_reg) ? idx : '0;
    assign bus.rf_w_data  = wb_state ? wb_val_reg :
                            (beat_done && ld_reg) ? bus.mem_rdata : '0;
endmodule
